sipo_frame_ctrl: RTL and testbench
==================================

SIPO_FRAME_CTRL -- requirements
Module: sipo_frame_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the data bits per frame and the width of the SIPO word.
REQ-002 The block SHALL have parameter STOP_CHK, default 1; when 1 the stop bit is checked, when 0 it is accepted unchecked.
REQ-003 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ser_in  in  1  serial data bit.
- ser_valid  in  1  ser_in is sampled this cycle; at most one bit per cycle.
- out_ready  in  1  consumer accepts word_out.
- clr_err  in  1  clears the sticky overrun flag.
- shift_en  out  1  SIPO shift strobe.
- word_out  out  WIDTH  assembled word.
- word_valid  out  1  word_out holds an unconsumed word.
- busy  out  1  a frame is in progress (state not IDLE).
- frame_err  out  1  one-cycle pulse on a bad stop bit.
- overrun  out  1  sticky: a completed word was dropped.

Function
REQ-004 The FSM SHALL have exactly these states: IDLE, DATA, STOP.
REQ-005 IDLE SHALL go to DATA when ser_valid=1 and ser_in=0 (start bit); ser_valid with ser_in=1 SHALL be ignored.
REQ-006 In DATA, each ser_valid cycle SHALL assert shift_en combinationally and shift ser_in into SIPO bit 0, moving bit i to bit i+1.
REQ-007 A bit counter SHALL count the data bits; after the WIDTH-th data bit the FSM SHALL go to STOP, so the first data bit ends in bit WIDTH-1.
REQ-008 In STOP, a ser_valid cycle SHALL return the FSM to IDLE.
- ser_in=1, or STOP_CHK=0: the SIPO contents SHALL be committed to word_out.
- ser_in=0 and STOP_CHK=1: frame_err SHALL pulse for one cycle and nothing is committed.
REQ-009 A commit SHALL load word_out and set word_valid on the clock edge that samples the stop bit; word_valid is high the following cycle.
REQ-010 word_out SHALL stay stable while word_valid=1 and out_ready=0.
REQ-011 word_valid SHALL clear on the edge where word_valid=1 and out_ready=1, unless a commit occurs on the same edge.
- In that case the new word SHALL load and word_valid SHALL stay 1.
REQ-012 If a commit occurs while word_valid=1 and out_ready=0:
- The new word SHALL be dropped.
- word_out SHALL be kept.
- overrun SHALL be set.
REQ-013 overrun SHALL clear only on clr_err=1; if an overrun event and clr_err=1 occur in the same cycle, set SHALL win.
REQ-014 Cycles with ser_valid=0 SHALL hold the state, the counter and the SIPO contents in every state.
REQ-015 busy SHALL be 1 exactly when the state is DATA or STOP.
REQ-016 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL reset to 0 on entering DATA, so it never wraps.

Reset
REQ-017 While rst=0, the block SHALL immediately (asynchronously) set:
- state = IDLE, counter = 0, SIPO = 0;
- word_out = 0, word_valid = 0, overrun = 0;
- frame_err = 0, shift_en = 0, busy = 0.
REQ-018 A reset asserted mid-frame SHALL abandon the partial frame without committing it; the first start bit after rst returns to 1 SHALL begin a new frame.

Structure
REQ-019 The state encoding and the counter-width constant SHALL live in a shared package, sipo_pkg.
REQ-020 The shift register SHALL be a sub-module, sipo_shift_en: a WIDTH-bit SIPO with a shift enable and an asynchronous active-low clear.
REQ-021 The FSM, counter, output register and flags SHALL be in sipo_frame_ctrl.

Verification
REQ-022 The bench SHALL cover these directed scenarios (WIDTH=4, STOP_CHK=1 unless noted):
- Basic frame: ser_valid every cycle with 0,1,0,1,1,1 (start, data, stop) and out_ready=1 -> word_out=4'b1011, word_valid high for 1 cycle, busy high for 5 cycles.
- Gapped bits: the same frame with ser_valid=0 cycles between bits -> word_out=4'b1011; shift_en count = 4.
- Bad stop: stop bit 0 -> frame_err pulses once, word_valid stays 0, FSM in IDLE.
- Backpressure: out_ready=0, frames 4'b1011 then 4'b0110 -> word_out stays 4'b1011, overrun=1; clr_err clears overrun.
- Simultaneous accept and commit: out_ready=1 on the stop-bit edge of the second frame -> word_out=4'b0110, word_valid stays 1, overrun=0.
- Reset mid-frame: rst=0 after 2 data bits, then a full frame 4'b1100 -> word_out=4'b1100, no stale bits.

Source files
------------

// File: rtl/sipo_pkg.sv
// -----------------------------------------------------------------------------
// sipo_pkg
// Shared definitions for the serial-to-parallel frame receiver.
//   state_e      : frame FSM state encoding (IDLE / DATA / STOP)
//   cnt_width()  : width of the data-bit counter for a given word width,
//                  ceil(log2(w+1)), so the counter can hold the value w
//   DEF_WIDTH    : default word width
//   DEF_CNT_W    : counter width for the default word width
// -----------------------------------------------------------------------------
package sipo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_STOP = 2'd2
    } state_e;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = cnt_width(DEF_WIDTH);

endpackage : sipo_pkg

// File: rtl/sipo_shift_en.sv
// -----------------------------------------------------------------------------
// sipo_shift_en
// WIDTH-bit serial-in / parallel-out shift register with shift enable.
// New bits enter at bit 0; on each enabled cycle bit i moves to bit i+1.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low clear
//   shift_en in   shift strobe
//   ser_in   in   serial bit shifted into bit 0
//   q        out  WIDTH-bit parallel contents
// -----------------------------------------------------------------------------
module sipo_shift_en #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    assign sr_d[0] = shift_en ? ser_in : sr_q[0];

    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_stage
            assign sr_d[gi] = shift_en ? sr_q[gi-1] : sr_q[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q = sr_q;

endmodule : sipo_shift_en

// File: rtl/sipo_frame_ctrl.sv
// -----------------------------------------------------------------------------
// sipo_frame_ctrl
// Receives frames of the form  start(0), WIDTH data bits (first bit ends up
// in the MSB), stop(1)  one bit per ser_valid cycle, and presents each good
// frame as a word with a valid/ready hand-off. A word completed while the
// previous one is still unconsumed is dropped and flags a sticky overrun.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   ser_in     in   serial data bit
//   ser_valid  in   ser_in is sampled this cycle
//   out_ready  in   consumer accepts word_out
//   clr_err    in   clears the sticky overrun flag
//   shift_en   out  SIPO shift strobe (combinational)
//   word_out   out  assembled word
//   word_valid out  word_out holds an unconsumed word
//   busy       out  a frame is in progress
//   frame_err  out  one-cycle pulse after a bad stop bit
//   overrun    out  sticky: a completed word was dropped
// -----------------------------------------------------------------------------
module sipo_frame_ctrl
    import sipo_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int STOP_CHK = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             out_ready,
    input  logic             clr_err,
    output logic             shift_en,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             ferr_q, ferr_d;
    logic             commit;
    logic             drop;
    logic [WIDTH-1:0] sipo_word;

    sipo_shift_en #(
        .WIDTH (WIDTH)
    ) u_sipo (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .ser_in   (ser_in),
        .q        (sipo_word)
    );

    // Frame FSM: next state, counter, shift strobe, commit / frame error.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_en = 1'b0;
        commit   = 1'b0;
        ferr_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ser_valid && !ser_in) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end
            end
            ST_DATA: begin
                if (ser_valid) begin
                    shift_en = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (ser_valid) begin
                    state_d = ST_IDLE;
                    if (ser_in || (STOP_CHK == 0)) begin
                        commit = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output word hand-off. A commit with the slot still full and no accept
    // this cycle loses the new word; an accept on the same edge as a commit
    // frees the slot, so the new word takes it and valid stays high.
    assign drop = commit && valid_q && !out_ready;

    always_comb begin
        word_d  = word_q;
        valid_d = valid_q;
        if (commit && !drop) begin
            word_d  = sipo_word;
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        // Set has priority over clear.
        if (drop) begin
            ovr_d = 1'b1;
        end else if (clr_err) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign word_out   = word_q;
    assign word_valid = valid_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;

endmodule : sipo_frame_ctrl

// File: tb/tb_sipo_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sipo_frame_ctrl
// Directed frame scenarios followed by randomized serial traffic, all checked
// against a frame-level reference model (a queue of received data bits).
// -----------------------------------------------------------------------------
module tb_sipo_frame_ctrl;

    localparam int WIDTH    = 4;
    localparam int STOP_CHK = 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ser_in = 1'b0;
    logic             ser_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic             clr_err = 1'b0;
    logic             shift_en;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             busy;
    logic             frame_err;
    logic             overrun;

    always #5 clk = ~clk;

    sipo_frame_ctrl #(
        .WIDTH    (WIDTH),
        .STOP_CHK (STOP_CHK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ser_in     (ser_in),
        .ser_valid  (ser_valid),
        .out_ready  (out_ready),
        .clr_err    (clr_err),
        .shift_en   (shift_en),
        .word_out   (word_out),
        .word_valid (word_valid),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: whether a frame is open, and the data bits seen so far.
    bit        m_busy;
    int        m_bits[$];
    int        m_word;
    bit        m_valid;
    bit        m_ovr;
    bit        m_ferr;

    // Per-scenario observation counters.
    int cnt_busy, cnt_shift, cnt_valid, cnt_ferr;

    function automatic void model_reset();
        m_busy  = 0;
        m_bits.delete();
        m_word  = 0;
        m_valid = 0;
        m_ovr   = 0;
        m_ferr  = 0;
    endfunction

    function automatic void model_step(input bit sv, input bit si, input bit rdy, input bit clr);
        bit commit = 0;
        bit bad    = 0;
        bit drop;
        int nw     = 0;
        if (sv) begin
            if (!m_busy) begin
                if (!si) begin
                    m_busy = 1;
                    m_bits.delete();
                end
            end else if (m_bits.size() < WIDTH) begin
                m_bits.push_back(int'(si));
            end else begin
                m_busy = 0;
                if (si || STOP_CHK == 0) begin
                    commit = 1;
                    foreach (m_bits[k]) nw = nw * 2 + m_bits[k];
                end else begin
                    bad = 1;
                end
            end
        end
        drop = commit && m_valid && !rdy;
        if (commit && !drop) begin
            m_word  = nw;
            m_valid = 1;
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        if (drop)     m_ovr = 1;
        else if (clr) m_ovr = 0;
        m_ferr = bad;
    endfunction

    function automatic void clr_counts();
        cnt_busy  = 0;
        cnt_shift = 0;
        cnt_valid = 0;
        cnt_ferr  = 0;
    endfunction

    // One clock cycle: check registered outputs, drive inputs, check the
    // combinational strobe, then advance the model on the rising edge.
    task automatic step(input bit sv, input bit si, input bit rdy, input bit clr);
        bit exp_shift;
        @(negedge clk);
        chk("word_out",   32'(word_out),   32'(m_word));
        chk("word_valid", 32'(word_valid), 32'(m_valid));
        chk("overrun",    32'(overrun),    32'(m_ovr));
        chk("frame_err",  32'(frame_err),  32'(m_ferr));
        chk("busy",       32'(busy),       32'(m_busy));
        cnt_busy  += int'(busy);
        cnt_valid += int'(word_valid);
        cnt_ferr  += int'(frame_err);
        ser_valid = sv;
        ser_in    = si;
        out_ready = rdy;
        clr_err   = clr;
        #1;
        exp_shift = sv && m_busy && (m_bits.size() < WIDTH);
        chk("shift_en", 32'(shift_en), 32'(exp_shift));
        cnt_shift += int'(shift_en);
        @(posedge clk);
        model_step(sv, si, rdy, clr);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, rdy, 1'b0);
    endtask

    // Start bit, WIDTH data bits MSB first, stop bit; gap idle cycles between bits.
    task automatic send_frame(input logic [WIDTH-1:0] w, input bit stop, input int gap,
                              input bit rdy, input bit rdy_stop);
        step(1'b1, 1'b0, rdy, 1'b0);
        idle(gap, rdy);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            step(1'b1, w[i], rdy, 1'b0);
            idle(gap, rdy);
        end
        step(1'b1, stop, rdy_stop, 1'b0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        ser_valid = 1'b0;
        ser_in    = 1'b0;
        out_ready = 1'b0;
        clr_err   = 1'b0;
        rst       = 1'b0;
        #1;
        chk("rst_word_out",   32'(word_out),   32'd0);
        chk("rst_word_valid", 32'(word_valid), 32'd0);
        chk("rst_overrun",    32'(overrun),    32'd0);
        chk("rst_frame_err",  32'(frame_err),  32'd0);
        chk("rst_busy",       32'(busy),       32'd0);
        chk("rst_shift_en",   32'(shift_en),   32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        apply_reset();

        // Basic frame, back-to-back bits.
        clr_counts();
        send_frame(4'b1011, 1'b1, 0, 1'b1, 1'b1);
        idle(3, 1'b1);
        chk("basic_word", 32'(word_out), 32'hB);
        chk("basic_valid_cycles", 32'(cnt_valid), 32'd1);
        chk("basic_busy_cycles", 32'(cnt_busy), 32'd5);
        $display("basic frame: word_out=%b", word_out);

        // Gapped bits.
        clr_counts();
        send_frame(4'b1011, 1'b1, 2, 1'b1, 1'b1);
        idle(3, 1'b1);
        chk("gap_word", 32'(word_out), 32'hB);
        chk("gap_shift_count", 32'(cnt_shift), 32'd4);
        $display("gapped frame: word_out=%b shifts=%0d", word_out, cnt_shift);

        // Bad stop bit.
        clr_counts();
        send_frame(4'b0101, 1'b0, 0, 1'b1, 1'b1);
        idle(3, 1'b1);
        chk("bad_ferr_pulses", 32'(cnt_ferr), 32'd1);
        chk("bad_valid_cycles", 32'(cnt_valid), 32'd0);
        chk("bad_idle", 32'(busy), 32'd0);
        $display("bad stop: frame_err pulses=%0d", cnt_ferr);

        // Backpressure: second word is dropped.
        send_frame(4'b1011, 1'b1, 0, 1'b0, 1'b0);
        send_frame(4'b0110, 1'b1, 0, 1'b0, 1'b0);
        idle(2, 1'b0);
        chk("bp_word", 32'(word_out), 32'hB);
        chk("bp_overrun", 32'(overrun), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp_overrun_clr", 32'(overrun), 32'd0);
        $display("backpressure: word_out=%b overrun cleared", word_out);

        // Accept and commit on the same edge.
        send_frame(4'b0110, 1'b1, 0, 1'b0, 1'b1);
        chk("acc_word", 32'(word_out), 32'h6);
        chk("acc_valid", 32'(word_valid), 32'd1);
        chk("acc_overrun", 32'(overrun), 32'd0);
        idle(2, 1'b1);
        $display("accept+commit: word_out=%b", word_out);

        // Reset mid-frame, then a clean frame.
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        apply_reset();
        send_frame(4'b1100, 1'b1, 0, 1'b1, 1'b1);
        idle(2, 1'b1);
        chk("rst_mid_word", 32'(word_out), 32'hC);
        $display("reset mid-frame: word_out=%b", word_out);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 699) apply_reset();
            step(($urandom % 4) != 0, $urandom % 2 == 1, ($urandom % 3) != 0, ($urandom % 16) == 0);
        end
        $display("random traffic: done");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_sipo_frame_ctrl
